input_mem_ctrl: RTL and testbench

Load/drain sequencer for the 4096 x 108-bit input image memory. It accepts a burst of pixel-window words on a valid/ready stream and writes them to consecutive addresses from 0. On command it reads the stored words back in address order to the downstream compute stream. It hides the memory's 1-cycle registered read latency with a 2-entry output buffer, so drain runs at one word per cycle when the consumer never stalls.

---
 rtl/input_mem_ctrl.sv | 114 +++++++++++
 tb/tb_input_mem_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/input_mem_ctrl.sv
// input_mem_ctrl: load/drain sequencer for the input image memory.
// Reads pass through a 2-entry buffer that hides the 1-cycle read latency.
module input_mem_ctrl #(
  parameter int ADD_SIZE = 12,
  parameter int DATA_SIZE = 108,
  parameter int DEPTH = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_start,
  input  logic                 drain_start,
  input  logic                 s_valid,
  input  logic [DATA_SIZE-1:0] s_data,
  input  logic                 s_last,
  output logic                 s_ready,
  output logic                 m_valid,
  output logic [DATA_SIZE-1:0] m_data,
  output logic                 m_last,
  input  logic                 m_ready,
  output logic                 mem_write_en,
  output logic [ADD_SIZE-1:0]  mem_write_address,
  output logic [DATA_SIZE-1:0] mem_write_data,
  output logic                 mem_read_en,
  output logic [ADD_SIZE-1:0]  mem_read_address,
  input  logic [DATA_SIZE-1:0] mem_read_data,
  output logic [ADD_SIZE:0]    word_count,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow
);
  localparam int W = ADD_SIZE + 1;
  typedef enum logic [1:0] {IDLE, LOAD, LOADED, DRAIN} state_t;
  state_t state_q;
  logic [W-1:0] wr_ptr_q, rd_ptr_q, sent_q, word_count_q;
  logic [DATA_SIZE-1:0] b0_q, b1_q;
  logic [1:0] cnt_q, slot;
  logic [2:0] occ;
  logic inflight_q, overflow_q, done_q, wr, rd, pop;
  always_comb begin
    s_ready = state_q == LOAD;
    wr = s_ready && s_valid;
    m_valid = cnt_q != 2'd0;
    m_data = m_valid ? b0_q : '0;
    m_last = m_valid && sent_q == word_count_q - W'(1);
    pop = m_valid && m_ready;
    occ = {1'b0, cnt_q} + {2'b0, inflight_q};
    rd = state_q == DRAIN && rd_ptr_q < word_count_q && occ < 3'd2 + {2'b0, pop};
    slot = cnt_q - {1'b0, pop};
    mem_write_en = wr;
    mem_write_address = wr ? wr_ptr_q[ADD_SIZE-1:0] : '0;
    mem_write_data = wr ? s_data : '0;
    mem_read_en = rd;
    mem_read_address = rd ? rd_ptr_q[ADD_SIZE-1:0] : '0;
    word_count = word_count_q;
    busy = state_q == LOAD || state_q == DRAIN;
    done = done_q;
    overflow = overflow_q;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      sent_q <= '0;
      word_count_q <= '0;
      b0_q <= '0;
      b1_q <= '0;
      cnt_q <= '0;
      inflight_q <= 1'b0;
      overflow_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      inflight_q <= rd;
      // returning read lands in the first free slot after this cycle's pop
      cnt_q <= cnt_q + {1'b0, inflight_q} - {1'b0, pop};
      b0_q <= inflight_q && slot == 2'd0 ? mem_read_data : pop ? b1_q : b0_q;
      b1_q <= inflight_q && slot == 2'd1 ? mem_read_data : b1_q;
      if (rd) rd_ptr_q <= rd_ptr_q + W'(1);
      if (pop) sent_q <= sent_q + W'(1);
      case (state_q)
        IDLE: if (load_start) begin
          state_q <= LOAD;
          wr_ptr_q <= '0;
          word_count_q <= '0;
          overflow_q <= 1'b0;
        end
        LOAD: if (wr) begin
          wr_ptr_q <= wr_ptr_q + W'(1);
          if (s_last || wr_ptr_q == W'(DEPTH - 1)) begin
            state_q <= LOADED;
            word_count_q <= wr_ptr_q + W'(1);
            overflow_q <= !s_last;
          end
        end
        LOADED: if (drain_start) begin
          state_q <= DRAIN;
          rd_ptr_q <= '0;
          sent_q <= '0;
        end else if (load_start) begin
          state_q <= LOAD;
          wr_ptr_q <= '0;
          word_count_q <= '0;
          overflow_q <= 1'b0;
        end
        DRAIN: if (pop && m_last) begin
          state_q <= IDLE;
          done_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_input_mem_ctrl.sv
// tb_input_mem_ctrl: directed bench for input_mem_ctrl with a registered-read memory model.
module tb_input_mem_ctrl;
  logic clk = 0, rst = 0;
  logic load_start = 0, drain_start = 0, s_valid = 0, s_last = 0, m_ready = 0;
  logic [107:0] s_data = '0, m_data, mem_write_data, mem_read_data;
  logic s_ready, m_valid, m_last, mem_write_en, mem_read_en, busy, done, overflow;
  logic [11:0] mem_write_address, mem_read_address;
  logic [12:0] word_count;
  logic [107:0] mem [4096];
  logic [107:0] golden [4096];
  int checks = 0, errors = 0;

  input_mem_ctrl dut (
    .clk(clk), .rst(rst), .load_start(load_start), .drain_start(drain_start),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
    .mem_write_en(mem_write_en), .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data), .mem_read_en(mem_read_en),
    .mem_read_address(mem_read_address), .mem_read_data(mem_read_data),
    .word_count(word_count), .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_write_en) mem[mem_write_address] <= mem_write_data;
    if (mem_read_en) mem_read_data <= mem[mem_read_address];
  end

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load(int n, bit with_last, bit also_drain, int base);
    load_start = 1;
    drain_start = also_drain;
    tick;
    load_start = 0;
    drain_start = 0;
    chk("load_busy", busy, 1);
    chk("load_sready", s_ready, 1);
    for (int i = 0; i < n; i++) begin
      golden[i] = {8'(base), 100'(i + 1)};
      s_valid = 1;
      s_data = golden[i];
      s_last = with_last && i == n - 1;
      #1;
      chk("wr_en", mem_write_en, 1);
      chk("wr_addr", mem_write_address, i);
      if (n <= 8) chk("wr_data", mem_write_data, golden[i]);
      tick;
    end
    s_valid = 0;
    s_last = 0;
    #1;
    chk("loaded_wc", word_count, n);
    chk("loaded_ovf", overflow, !with_last);
    chk("loaded_sready", s_ready, 0);
    chk("loaded_busy", busy, 0);
    chk("loaded_wr_en", mem_write_en, 0);
  endtask

  task automatic drain(int n, bit toggle, bit also_load);
    int idx, issued, cyc;
    bit pop, stall;
    logic [107:0] hold;
    idx = 0; issued = 0; cyc = 0; stall = 0; hold = '0;
    drain_start = 1;
    load_start = also_load;
    m_ready = 0;
    tick;
    drain_start = 0;
    load_start = 0;
    chk("drain_wc", word_count, n);
    chk("drain_sready", s_ready, 0);
    chk("drain_busy", busy, 1);
    while (idx < n && cyc < n * 4 + 20) begin
      m_ready = toggle ? (cyc % 3 == 0) : 1'b1;
      #1;
      if (cyc < 2) chk("lat_novalid", m_valid, 0);
      if (cyc == 2) chk("lat_valid", m_valid, 1);
      if (stall) begin
        chk("stall_valid", m_valid, 1);
        chk("stall_data", m_data, hold);
      end
      pop = m_valid && m_ready;
      if (mem_read_en) begin
        chk("rd_addr", mem_read_address, issued);
        chk("rd_room", (issued - idx - int'(pop)) < 2, 1);
        issued++;
      end
      if (m_valid) chk("last_flag", m_last, idx == n - 1);
      if (pop) begin
        chk("data", m_data, golden[idx]);
        idx++;
      end
      stall = m_valid && !m_ready;
      hold = m_data;
      cyc++;
      tick;
    end
    chk("drain_complete", idx, n);
    chk("rd_total", issued, n);
    chk("done_pulse", done, 1);
    chk("idle_busy", busy, 0);
    chk("idle_valid", m_valid, 0);
    tick;
    chk("done_clear", done, 0);
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_sready"}, s_ready, 0);
    chk({tag, "_mvalid"}, m_valid, 0);
    chk({tag, "_mdata"}, m_data, 0);
    chk({tag, "_mlast"}, m_last, 0);
    chk({tag, "_wen"}, mem_write_en, 0);
    chk({tag, "_waddr"}, mem_write_address, 0);
    chk({tag, "_wdata"}, mem_write_data, 0);
    chk({tag, "_ren"}, mem_read_en, 0);
    chk({tag, "_raddr"}, mem_read_address, 0);
    chk({tag, "_wc"}, word_count, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_ovf"}, overflow, 0);
  endtask

  initial begin
    tick;
    tick;
    chk_zero("reset");
    rst = 1;
    tick;
    drain_start = 1;
    tick;
    drain_start = 0;
    chk("idle_drain_ignored", busy, 0);
    load(4, 1, 0, 0);
    chk("mem0", mem[0], 108'h1);
    chk("mem3", mem[3], 108'h4);
    drain(4, 0, 0);
    load(6, 1, 0, 1);
    drain(6, 1, 0);
    load(5, 1, 1, 2);
    drain(5, 0, 1);
    load(4096, 0, 0, 3);
    drain(4096, 0, 0);
    load(4, 1, 0, 4);
    drain_start = 1;
    m_ready = 1;
    tick;
    drain_start = 0;
    tick;
    tick;
    tick;
    tick;
    chk("pre_rst_word2", m_data, golden[2]);
    rst = 0;
    tick;
    chk_zero("midrst");
    rst = 1;
    drain_start = 1;
    tick;
    drain_start = 0;
    chk("postrst_busy", busy, 0);
    chk("postrst_ren", mem_read_en, 0);
    tick;
    chk("postrst_valid", m_valid, 0);
    load(2, 1, 0, 5);
    drain(2, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
